// File: rtl/decode_buffer.sv
// decode_buffer_pkg / decode_buffer
//
// Multi-lane RISC-V decode stage with an output queue, placed between fetch
// and issue. Each cycle up to NR_LANES instructions are decoded into
// scoreboard_entry_t records and written into a DEPTH-entry circular queue
// that issue drains one entry per cycle. SYSTEM and MISCMEM instructions are
// serialising: once one is accepted, no further instruction is accepted until
// it has been popped, so later decodes see any CSR side effects.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   fetch_valid_i      per-lane valid (contiguous prefix from lane 0)
//   fetch_instr_i      per-lane 32-bit instruction
//   fetch_pc_i         per-lane PC
//   fetch_ack_o        number of prefix lanes consumed this cycle
//   issue_entry_o      registered head-of-queue record
//   issue_valid_o      head record is valid (queue non-empty)
//   issue_ready_i      issue takes the head this cycle
//   flush_i            drop all queued state and the current fetch beat
//   priv_i, tsr_i, tw_i, tvm_i, debug_mode_i   privilege context for decode
//   count_o            current queue occupancy

package decode_buffer_pkg;
    localparam int RV_XLEN = 64;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [2:0] {
        FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_CSR
    } fu_t;

    typedef enum logic [5:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        LB, LH, LW, LD, LBU, LHU, LWU,
        SB, SH, SW, SD,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI,
        ECALL, EBREAK, MRET, SRET, DRET, WFI, SFENCE_VMA,
        FENCE, FENCE_I
    } fu_op_t;

    localparam logic [RV_XLEN-1:0] ILLEGAL_INSTR  = 64'd2;
    localparam logic [RV_XLEN-1:0] BREAKPOINT     = 64'd3;
    localparam logic [RV_XLEN-1:0] ENV_CALL_UMODE = 64'd8;
    localparam logic [RV_XLEN-1:0] ENV_CALL_SMODE = 64'd9;
    localparam logic [RV_XLEN-1:0] ENV_CALL_MMODE = 64'd11;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    typedef struct packed {
        logic               valid;
        logic [RV_XLEN-1:0] cause;
        logic [RV_XLEN-1:0] tval;
    } exception_t;

    typedef struct packed {
        logic [4:0] rs1;
    } operand1_t;

    typedef struct packed {
        logic               use_imm;
        logic [4:0]         rs2;
        logic [RV_XLEN-1:0] imm;
    } operand2_t;

    typedef struct packed {
        logic [4:0] rd;
    } result_t;

    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        fu_t                fu;
        fu_op_t             op;
        operand1_t          operand1;
        operand2_t          operand2;
        result_t            result;
        exception_t         ex;
    } scoreboard_entry_t;
endpackage

module decode_buffer
    import decode_buffer_pkg::*;
#(
    parameter int NR_LANES = 2,
    parameter int DEPTH    = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NR_LANES-1:0]                 fetch_valid_i,
    input  logic [NR_LANES-1:0][31:0]           fetch_instr_i,
    input  logic [NR_LANES-1:0][RV_XLEN-1:0]    fetch_pc_i,
    output logic [$clog2(NR_LANES+1)-1:0]       fetch_ack_o,
    output scoreboard_entry_t                   issue_entry_o,
    output logic                                issue_valid_o,
    input  logic                                issue_ready_i,
    input  logic                                flush_i,
    input  priv_lvl_t                           priv_i,
    input  logic                                tsr_i,
    input  logic                                tw_i,
    input  logic                                tvm_i,
    input  logic                                debug_mode_i,
    output logic [$clog2(DEPTH+1)-1:0]          count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ACK_W = $clog2(NR_LANES+1);

    // Queue slot: the decoded record plus the flag that releases serial_lock on pop.
    typedef struct packed {
        logic              serial;
        scoreboard_entry_t entry;
    } slot_t;

    function automatic scoreboard_entry_t decode_instr(
        input logic [31:0]        instr,
        input logic [RV_XLEN-1:0] pc,
        input priv_lvl_t          priv,
        input logic               tsr,
        input logic               tw,
        input logic               tvm,
        input logic               dbg
    );
        scoreboard_entry_t         e;
        logic                      illegal, ecall, ebreak;
        logic [2:0]                f3;
        logic [6:0]                f7;
        logic [4:0]                rs1, rd;
        logic signed [RV_XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

        f3      = instr[14:12];
        f7      = instr[31:25];
        rs1     = instr[19:15];
        rd      = instr[11:7];
        imm_i   = {{(RV_XLEN-12){instr[31]}}, instr[31:20]};
        imm_s   = {{(RV_XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
        imm_b   = {{(RV_XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u   = {{(RV_XLEN-32){instr[31]}}, instr[31:12], 12'b0};
        imm_j   = {{(RV_XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        illegal = (instr[1:0] != 2'b11);
        ecall   = 1'b0;
        ebreak  = 1'b0;

        e                   = '0;
        e.pc                = pc;
        e.result.rd         = rd;
        e.operand1.rs1      = rs1;
        e.operand2.rs2      = instr[24:20];

        case (instr[6:0])
            OPC_LOAD: begin
                e.fu = FU_LOAD; e.operand2.use_imm = 1'b1; e.operand2.imm = imm_i;
                case (f3)
                    3'd0: e.op = LB;  3'd1: e.op = LH;  3'd2: e.op = LW;  3'd3: e.op = LD;
                    3'd4: e.op = LBU; 3'd5: e.op = LHU; 3'd6: e.op = LWU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                e.fu = FU_STORE; e.operand2.use_imm = 1'b1; e.operand2.imm = imm_s; e.result.rd = '0;
                case (f3)
                    3'd0: e.op = SB; 3'd1: e.op = SH; 3'd2: e.op = SW; 3'd3: e.op = SD;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                e.fu = FU_CTRL_FLOW; e.operand2.imm = imm_b; e.result.rd = '0;
                case (f3)
                    3'd0: e.op = BEQ; 3'd1: e.op = BNE;  3'd4: e.op = BLT;
                    3'd5: e.op = BGE; 3'd6: e.op = BLTU; 3'd7: e.op = BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                e.fu = FU_CTRL_FLOW; e.op = JAL; e.operand2.use_imm = 1'b1; e.operand2.imm = imm_j;
            end
            OPC_JALR: begin
                e.fu = FU_CTRL_FLOW; e.op = JALR; e.operand2.use_imm = 1'b1; e.operand2.imm = imm_i;
                if (f3 != 3'd0) illegal = 1'b1;
            end
            OPC_LUI: begin
                e.fu = FU_ALU; e.op = LUI; e.operand2.use_imm = 1'b1; e.operand2.imm = imm_u;
            end
            OPC_AUIPC: begin
                e.fu = FU_ALU; e.op = AUIPC; e.operand2.use_imm = 1'b1; e.operand2.imm = imm_u;
            end
            OPC_OP: begin
                e.fu = FU_ALU;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'd0: e.op = ADD; 3'd1: e.op = SLL; 3'd2: e.op = SLT; 3'd3: e.op = SLTU;
                        3'd4: e.op = XOR; 3'd5: e.op = SRL; 3'd6: e.op = OR;  default: e.op = AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
                    e.op = SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
                    e.op = SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                e.fu = FU_ALU; e.operand2.use_imm = 1'b1; e.operand2.imm = imm_i;
                case (f3)
                    3'd0: e.op = ADD; 3'd2: e.op = SLT; 3'd3: e.op = SLTU;
                    3'd4: e.op = XOR; 3'd6: e.op = OR;  3'd7: e.op = AND;
                    3'd1: begin
                        e.op = SLL;
                        if (instr[31:26] != 6'b000000) illegal = 1'b1;
                    end
                    default: begin
                        if (instr[31:26] == 6'b000000)      e.op = SRL;
                        else if (instr[31:26] == 6'b010000) e.op = SRA;
                        else                                illegal = 1'b1;
                    end
                endcase
            end
            OPC_MISCMEM: begin
                e.fu = FU_CSR;
                case (f3)
                    3'd0:    e.op = FENCE;
                    3'd1:    e.op = FENCE_I;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_SYSTEM: begin
                e.fu = FU_CSR;
                if (f3 == 3'd0) begin
                    if (rd != 5'd0) begin
                        illegal = 1'b1;
                    end else begin
                        case (instr[31:20])
                            12'h000: begin e.op = ECALL;  ecall  = 1'b1; if (rs1 != 5'd0) illegal = 1'b1; end
                            12'h001: begin e.op = EBREAK; ebreak = 1'b1; if (rs1 != 5'd0) illegal = 1'b1; end
                            12'h302: begin
                                e.op = MRET;
                                if (rs1 != 5'd0 || priv != PRIV_LVL_M) illegal = 1'b1;
                            end
                            // xRET/WFI are matched on rs1 == 0 only; rs2 is part of funct12.
                            12'h102: begin
                                e.op = SRET;
                                if (rs1 != 5'd0 || priv == PRIV_LVL_U || (priv == PRIV_LVL_S && tsr))
                                    illegal = 1'b1;
                            end
                            12'h105: begin
                                e.op = WFI;
                                if (rs1 != 5'd0 || (priv != PRIV_LVL_M && tw)) illegal = 1'b1;
                            end
                            12'h7b2: begin
                                e.op = DRET;
                                if (rs1 != 5'd0 || !dbg) illegal = 1'b1;
                            end
                            default: begin
                                e.op = SFENCE_VMA;
                                if (f7 != 7'b0001001 || priv == PRIV_LVL_U || (priv == PRIV_LVL_S && tvm))
                                    illegal = 1'b1;
                            end
                        endcase
                    end
                end else begin
                    e.operand2.imm = {{(RV_XLEN-12){1'b0}}, instr[31:20]};
                    case (f3)
                        3'd1: e.op = CSRRW;  3'd2: e.op = CSRRS;  3'd3: e.op = CSRRC;
                        3'd5: e.op = CSRRWI; 3'd6: e.op = CSRRSI; 3'd7: e.op = CSRRCI;
                        default: illegal = 1'b1;
                    endcase
                    // csr[9:8] encodes the lowest privilege allowed to access it.
                    if (instr[29:28] > priv) illegal = 1'b1;
                    // Writes to read-only CSRs (csr[11:10] == 2'b11).
                    if (instr[31:30] == 2'b11 && (f3[1:0] == 2'b01 || rs1 != 5'd0)) illegal = 1'b1;
                    // satp access from S-mode traps when TVM is set.
                    if (instr[31:20] == 12'h180 && priv == PRIV_LVL_S && tvm) illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        // An illegal result takes precedence over ECALL/EBREAK.
        if (illegal) begin
            e.fu = FU_NONE;
            e.ex = '{1'b1, ILLEGAL_INSTR, {{(RV_XLEN-32){1'b0}}, instr}};
        end else if (ecall) begin
            e.ex.valid = 1'b1;
            case (priv)
                PRIV_LVL_U: e.ex.cause = ENV_CALL_UMODE;
                PRIV_LVL_S: e.ex.cause = ENV_CALL_SMODE;
                default:    e.ex.cause = ENV_CALL_MMODE;
            endcase
        end else if (ebreak) begin
            e.ex.valid = 1'b1;
            e.ex.cause = BREAKPOINT;
        end
        return e;
    endfunction

    slot_t             mem_q [DEPTH];
    slot_t             mem_d [DEPTH];
    slot_t             head_q, head_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d, free;
    logic              serial_lock_q, serial_lock_d;
    logic              valid_q, valid_d;
    scoreboard_entry_t dec [NR_LANES];
    logic [NR_LANES-1:0] lane_serial, accept;
    logic [ACK_W-1:0]  ack;
    logic              pop;

    always_comb begin
        for (int k = 0; k < NR_LANES; k++) begin
            dec[k] = decode_instr(fetch_instr_i[k], fetch_pc_i[k], priv_i,
                                  tsr_i, tw_i, tvm_i, debug_mode_i);
            lane_serial[k] = (fetch_instr_i[k][6:0] == OPC_SYSTEM) ||
                             (fetch_instr_i[k][6:0] == OPC_MISCMEM);
        end
    end

    // Accept a contiguous prefix of lanes: stop at the first invalid lane, when
    // the queue has no room (judged on registered count only), or right after
    // a serialising lane.
    always_comb begin : accept_logic
        logic go;
        go     = rst_ni && !serial_lock_q && !flush_i;
        accept = '0;
        ack    = '0;
        free   = CNT_W'(DEPTH) - count_q;
        for (int k = 0; k < NR_LANES; k++) begin
            if (go && fetch_valid_i[k] && (CNT_W'(k) < free)) begin
                accept[k] = 1'b1;
                ack       = ACK_W'(k + 1);
                if (lane_serial[k]) go = 1'b0;
            end else begin
                go = 1'b0;
            end
        end
    end

    assign pop = valid_q && issue_ready_i && !flush_i;

    // Next-state: the head register is loaded from the post-write storage so an
    // entry written into an empty queue appears at the head one cycle later.
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < NR_LANES; k++) begin
            if (accept[k]) mem_d[wptr_q + PTR_W'(k)] = '{serial: lane_serial[k], entry: dec[k]};
        end
        wptr_d        = wptr_q + PTR_W'(ack);
        rptr_d        = rptr_q + PTR_W'(pop);
        count_d       = count_q + CNT_W'(ack) - CNT_W'(pop);
        serial_lock_d = serial_lock_q;
        if (|(accept & lane_serial))     serial_lock_d = 1'b1;
        else if (pop && head_q.serial)   serial_lock_d = 1'b0;
        if (flush_i) begin
            wptr_d        = '0;
            rptr_d        = '0;
            count_d       = '0;
            serial_lock_d = 1'b0;
        end
        valid_d = (count_d != '0);
        head_d  = valid_d ? mem_d[rptr_d] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            serial_lock_q <= 1'b0;
            valid_q       <= 1'b0;
            head_q        <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            serial_lock_q <= serial_lock_d;
            valid_q       <= valid_d;
            head_q        <= head_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign fetch_ack_o   = ack;
    assign issue_entry_o = head_q.entry;
    assign issue_valid_o = valid_q;
    assign count_o       = count_q;
endmodule

// File: tb/tb_decode_buffer.sv
// tb_decode_buffer: directed self-checking bench for decode_buffer
// (NR_LANES=2, DEPTH=8). Inputs are driven on the falling edge and outputs
// sampled 1 time unit later, away from the rising edge.
module tb_decode_buffer;
    import decode_buffer_pkg::*;

    localparam logic [31:0] I_LW    = 32'h00812283;  // lw x5,8(x2)
    localparam logic [31:0] I_NOP   = 32'h00000013;
    localparam logic [31:0] I_CSRRW = 32'h300110F3;  // csrrw x1,mstatus,x2
    localparam logic [31:0] I_FENCE = 32'h0000000F;
    localparam logic [31:0] I_MRET  = 32'h30200073;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_SRET  = 32'h10200073;

    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b0;
    logic [1:0]                fetch_valid_i;
    logic [1:0][31:0]          fetch_instr_i;
    logic [1:0][RV_XLEN-1:0]   fetch_pc_i;
    logic [1:0]                fetch_ack_o;
    scoreboard_entry_t         issue_entry_o;
    logic                      issue_valid_o;
    logic                      issue_ready_i;
    logic                      flush_i;
    priv_lvl_t                 priv_i;
    logic                      tsr_i, tw_i, tvm_i, debug_mode_i;
    logic [3:0]                count_o;

    int n_chk = 0;
    int n_bad = 0;

    decode_buffer #(.NR_LANES(2), .DEPTH(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .fetch_valid_i(fetch_valid_i), .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i),
        .fetch_ack_o(fetch_ack_o),
        .issue_entry_o(issue_entry_o), .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .flush_i(flush_i),
        .priv_i(priv_i), .tsr_i(tsr_i), .tw_i(tw_i), .tvm_i(tvm_i), .debug_mode_i(debug_mode_i),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addi(input int v);
        logic [11:0] imm;
        imm = 12'(v);
        return {imm, 20'h00093};  // addi x1,x0,v
    endfunction

    task automatic idle();
        fetch_valid_i = '0;
        fetch_instr_i = '0;
        fetch_pc_i    = '0;
        issue_ready_i = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic push2(input logic [31:0] a, input logic [31:0] b, input logic [1:0] vld);
        fetch_valid_i    = vld;
        fetch_instr_i[0] = a;
        fetch_instr_i[1] = b;
    endtask

    // Push one serialising/system instruction, capture its decoded record, pop it.
    task automatic sys_one(input string tag, input logic [31:0] ins, output scoreboard_entry_t e);
        push2(ins, I_NOP, 2'b01);
        #1 check({tag, "_ack"}, 64'(fetch_ack_o), 64'd1);
        tick();
        fetch_valid_i = '0;
        #1 e = issue_entry_o;
        issue_ready_i = 1'b1;
        tick();
        issue_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        scoreboard_entry_t e;
        int mq[$];
        int mcount, seq, popped, eack, nv, pop;
        logic rdy;

        idle();
        priv_i = PRIV_LVL_M;
        tsr_i = 1'b0; tw_i = 1'b0; tvm_i = 1'b0; debug_mode_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        #1;
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_valid", 64'(issue_valid_o), 64'd0);
        check("rst_ack",   64'(fetch_ack_o), 64'd0);
        check("rst_entry", 64'(|issue_entry_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Two-lane fill
        push2(I_LW, I_NOP, 2'b11);
        fetch_pc_i[0] = 64'h1000;
        fetch_pc_i[1] = 64'h1004;
        #1 check("fill_ack", 64'(fetch_ack_o), 64'd2);
        tick();
        idle();
        #1;
        check("fill_count", 64'(count_o), 64'd2);
        check("fill_valid", 64'(issue_valid_o), 64'd1);
        check("fill_fu",    64'(issue_entry_o.fu), 64'(FU_LOAD));
        check("fill_op",    64'(issue_entry_o.op), 64'(LW));
        check("fill_rd",    64'(issue_entry_o.result.rd), 64'd5);
        check("fill_rs1",   64'(issue_entry_o.operand1.rs1), 64'd2);
        check("fill_imm",   issue_entry_o.operand2.imm, 64'd8);
        check("fill_pc",    issue_entry_o.pc, 64'h1000);
        check("fill_ex",    64'(issue_entry_o.ex.valid), 64'd0);

        // Full / wrap: 20 ADDIs with imm = sequence number
        do_reset();
        mcount = 0; seq = 0; popped = 0;
        for (int cyc = 0; cyc < 100 && popped < 20; cyc++) begin
            rdy = (cyc >= 5);
            nv  = (20 - seq >= 2) ? 2 : 20 - seq;
            push2(addi(seq), addi(seq + 1), (nv == 2) ? 2'b11 : (nv == 1) ? 2'b01 : 2'b00);
            issue_ready_i = rdy;
            #1;
            check("wrap_count", 64'(count_o), 64'(mcount));
            check("wrap_valid", 64'(issue_valid_o), 64'(mcount != 0));
            eack = (nv < 8 - mcount) ? nv : 8 - mcount;
            check("wrap_ack", 64'(fetch_ack_o), 64'(eack));
            pop = 0;
            if (mcount != 0 && rdy) begin
                check("wrap_order", issue_entry_o.operand2.imm, 64'(mq[0]));
                void'(mq.pop_front());
                popped++;
                pop = 1;
            end
            for (int i = 0; i < eack; i++) mq.push_back(seq + i);
            seq    += eack;
            mcount += eack - pop;
            tick();
        end
        check("wrap_popped", 64'(popped), 64'd20);
        idle();

        // Serialisation: CSR in lane 0 blocks lane 1 until it pops
        do_reset();
        push2(I_CSRRW, addi(7), 2'b11);
        #1 check("ser_ack", 64'(fetch_ack_o), 64'd1);
        tick();
        push2(addi(7), addi(8), 2'b11);
        #1;
        check("ser_lock_ack", 64'(fetch_ack_o), 64'd0);
        check("ser_count",    64'(count_o), 64'd1);
        check("ser_op",       64'(issue_entry_o.op), 64'(CSRRW));
        check("ser_fu",       64'(issue_entry_o.fu), 64'(FU_CSR));
        tick();
        #1 check("ser_hold_ack", 64'(fetch_ack_o), 64'd0);
        issue_ready_i = 1'b1;
        #1 check("ser_pop_ack", 64'(fetch_ack_o), 64'd0);
        tick();
        issue_ready_i = 1'b0;
        #1;
        check("ser_resume_ack", 64'(fetch_ack_o), 64'd2);
        check("ser_empty",      64'(count_o), 64'd0);
        tick();
        idle();
        #1;
        check("ser_count2", 64'(count_o), 64'd2);
        check("ser_head",   issue_entry_o.operand2.imm, 64'd7);

        // Serialising lane 1 is the last lane accepted
        do_reset();
        push2(addi(1), I_FENCE, 2'b11);
        #1 check("fence_ack", 64'(fetch_ack_o), 64'd2);
        tick();
        push2(addi(2), I_NOP, 2'b01);
        #1 check("fence_lock_ack", 64'(fetch_ack_o), 64'd0);
        idle();

        // Privilege checks in S-mode
        do_reset();
        priv_i = PRIV_LVL_S;
        sys_one("mret", I_MRET, e);
        check("mret_exv",   64'(e.ex.valid), 64'd1);
        check("mret_cause", e.ex.cause, 64'd2);
        check("mret_tval",  e.ex.tval, 64'h30200073);
        check("mret_fu",    64'(e.fu), 64'(FU_NONE));
        sys_one("ecall", I_ECALL, e);
        check("ecall_exv",   64'(e.ex.valid), 64'd1);
        check("ecall_cause", e.ex.cause, 64'd9);
        tsr_i = 1'b1;
        sys_one("sret_tsr", I_SRET, e);
        check("sret_tsr_exv",   64'(e.ex.valid), 64'd1);
        check("sret_tsr_cause", e.ex.cause, 64'd2);
        tsr_i = 1'b0;
        sys_one("sret", I_SRET, e);
        check("sret_exv", 64'(e.ex.valid), 64'd0);
        check("sret_op",  64'(e.op), 64'(SRET));
        sys_one("compr", 32'h00000001, e);
        check("compr_cause", e.ex.cause, 64'd2);
        check("compr_tval",  e.ex.tval, 64'd1);
        priv_i = PRIV_LVL_M;

        // Flush with 5 queued, lock set, issue ready
        do_reset();
        push2(addi(1), addi(2), 2'b11);
        tick();
        push2(addi(3), addi(4), 2'b11);
        tick();
        push2(I_CSRRW, addi(5), 2'b11);
        #1 check("flush_pre_ack", 64'(fetch_ack_o), 64'd1);
        tick();
        push2(addi(5), addi(6), 2'b11);
        flush_i = 1'b1;
        issue_ready_i = 1'b1;
        #1;
        check("flush_count5", 64'(count_o), 64'd5);
        check("flush_ack",    64'(fetch_ack_o), 64'd0);
        tick();
        flush_i = 1'b0;
        issue_ready_i = 1'b0;
        #1;
        check("flush_count", 64'(count_o), 64'd0);
        check("flush_valid", 64'(issue_valid_o), 64'd0);
        check("flush_newack", 64'(fetch_ack_o), 64'd2);
        tick();
        idle();
        #1;
        check("flush_refill", 64'(count_o), 64'd2);
        check("flush_head",   issue_entry_o.operand2.imm, 64'd5);

        // Asynchronous reset mid-cycle with 3 queued
        do_reset();
        push2(addi(1), addi(2), 2'b11);
        tick();
        push2(addi(3), addi(4), 2'b01);
        tick();
        idle();
        #1 check("arst_count3", 64'(count_o), 64'd3);
        #1 rst_ni = 1'b0;
        #1;
        check("arst_count", 64'(count_o), 64'd0);
        check("arst_valid", 64'(issue_valid_o), 64'd0);
        check("arst_entry", 64'(|issue_entry_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/decode_buffer.md
# decode_buffer

Parametrised, multi-lane decode stage with an output queue. Sits between the fetch unit and the issue/scoreboard stage. Each cycle it accepts up to `NR_LANES` 32-bit instructions, decodes them into `scoreboard_entry_t` records (LOAD, STORE, MISCMEM, SYSTEM, OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH), and queues the records in a `DEPTH`-entry FIFO drained one per cycle by issue. Compared with single-instruction combinational decode, it adds lane parallelism, buffering, serialisation of SYSTEM/MISCMEM instructions, and flush.

## Interface
- `NR_LANES`, 2: instructions offered per cycle (1..4).
- `DEPTH`, 8: queue entries. Must be a power of two and ≥ 2·`NR_LANES`.
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: asynchronous, active-low reset. One clock; all state is reset asynchronously.
- `fetch_valid_i` in, `NR_LANES`: per-lane valid. Valid lanes form a contiguous prefix starting at lane 0.
- `fetch_instr_i` in, `NR_LANES`×32: instruction per lane.
- `fetch_pc_i` in, `NR_LANES`×`RV_XLEN`: PC per lane.
- `fetch_ack_o` out, $clog2(`NR_LANES`+1): number of prefix lanes consumed this cycle.
- `issue_entry_o` out, `scoreboard_entry_t`: head of the queue.
- `issue_valid_o` out, 1: head is valid.
- `issue_ready_i` in, 1: issue takes the head this cycle.
- `flush_i` in, 1: discard all queued and in-flight state.
- `priv_i` in, `priv_lvl_t`; `tsr_i`, `tw_i`, `tvm_i`, `debug_mode_i` in, 1 each: privilege context, sampled combinationally in the accept cycle.
- `count_o` out, $clog2(`DEPTH`+1): current occupancy.

## Operation
- **Per-lane decode** is combinational on `fetch_instr_i`. Rules:
  - `instr[1:0] != 2'b11` or an unknown opcode: `is_illegal`.
  - SRET and WFI match `rs1 == 0`, not the duplicated `rs2` test.
- **Illegal instructions** produce `ex = '{1'b1, ILLEGAL_INSTR, instr}`, with tval zero-extended to `RV_XLEN`, and `fu = FU_NONE`.
- **Exception priority:** an illegal result overrides an ECALL/EBREAK exception.
- **Free space:** `free = DEPTH - count`. Lane k is accepted iff all of the following hold:
  - `fetch_valid_i[k]`
  - lanes 0..k-1 are accepted
  - k < `free`
  - `serial_lock` is clear
  - no lane j < k in this beat is serialising
- **Serialising lanes** are opcode SYSTEM or MISCMEM, whether legal or illegal.
- **Entering a serialising lane** sets `serial_lock` in the same beat. That lane is the last one accepted in the beat.
- **`serial_lock`** clears on the cycle the serialising entry is popped: `issue_valid_o && issue_ready_i` with head flagged serial, tracked by a per-entry `serial` bit. From the next cycle, acceptance resumes, and the privilege inputs then reflect any CSR side effects.
- **`fetch_ack_o`** equals the number of accepted lanes. Fetch must advance by exactly that many instructions.
- **Queue:** circular, with write/read pointers of $clog2(`DEPTH`) bits that wrap modulo `DEPTH`. Lanes are written in lane order at `wptr`, `wptr+1`, and so on.
- **Simultaneous push and pop:** allowed. `count_next = count + ack - pop`.
- **Pop** happens when `issue_valid_o && issue_ready_i`.
- **Flush:** `flush_i` has priority over everything. In that cycle `fetch_ack_o` = 0 and no pop occurs. Next cycle: `count` = 0, pointers = 0, `serial_lock` = 0.
- **Reset values:** `count_o` = 0, `issue_valid_o` = 0, `fetch_ack_o` = 0, `issue_entry_o` = '0, pointers = 0, `serial_lock` = 0.

## Timing
- **Latency:** an instruction accepted in cycle N is visible at the head no earlier than N+1. `issue_valid_o` = (`count` != 0) is registered state.
- **Throughput:** one pop per cycle when non-empty; up to `NR_LANES` pushes per cycle.
- **Full:** `count` == `DEPTH` gives `fetch_ack_o` = 0. A pop in the same cycle does not free space for that cycle's push; `free` uses the registered `count`.
- **Back-to-back serialising instructions:** each incurs at least 2 cycles of accept-to-accept gap (accept at N, pop at ≥ N+1, next accept at ≥ N+2).
- **`issue_entry_o`** is the registered RAM output at `rptr` and is stable while `issue_valid_o && !issue_ready_i`.
- **Reset mid-operation:** all outputs return to their reset values immediately, asynchronously; no queued entry survives.

## Test plan
- **Two-lane fill.** Stimulus: M-mode, `NR_LANES`=2, lanes = LW x5,8(x2) (0x00812283) and 0x00000013, `issue_ready_i`=0.
  - `fetch_ack_o`=2.
  - Next cycle: `count_o`=2 and head entry = `fu` FU_LOAD, `op` LW, `result.rd`=5, `operand1.rs1`=2, `operand2` imm=8.
- **Full/wrap.** Stimulus: hold `issue_ready_i`=0 and push until `count_o`=8; then set `issue_ready_i`=1 for 3 cycles while offering 2 lanes.
  - `fetch_ack_o`=0 while full.
  - Pointers wrap cleanly.
  - FIFO order is preserved across 20 instructions.
- **Serialisation.** Stimulus: lane0 = CSRRW x1,mstatus,x2 and lane1 = ADDI.
  - `fetch_ack_o`=1.
  - `fetch_ack_o` stays 0 until the CSR entry pops, then ADDI is accepted the cycle after.
- **Privilege checks.** Stimulus: `priv_i`=S.
  - MRET 0x30200073 gives `ex` = {1, ILLEGAL_INSTR, 0x30200073}.
  - ECALL 0x00000073 gives cause ENV_CALL_SMODE.
  - SRET 0x10200073 with `tsr_i`=1 is illegal; with `tsr_i`=0 it is legal.
- **Flush.** Stimulus: `flush_i`=1 with `count_o`=5, `serial_lock` set, and `issue_ready_i`=1.
  - `fetch_ack_o`=0 that cycle.
  - Next cycle: `count_o`=0, `issue_valid_o`=0, and new fetch is accepted.
- **Async reset.** Stimulus: drop `rst_ni` mid-cycle with `count_o`=3.
  - `issue_valid_o` and `count_o` go to 0 before the next clock edge.
